dc_fwd_ctrl: RTL and testbench

- Parametrised decode-stage hazard controller for the pipelined MIPS core.
- Tracks destination-register tags of in-flight instructions over a configurable number of downstream stages (stage 1 = EX, 2 = MEM, 3 = WB).
- Drives the operand forwarding selects for both source operands.
- Inserts load-use stall bubbles and squashes wrong-path slots on a taken branch.
- Keeps a saturating stall-cycle counter.

---
 rtl/dc_fwd_ctrl.sv | 94 +++++++++
 tb/tb_dc_fwd_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dc_fwd_ctrl.sv
// Decode-stage hazard controller: tracks in-flight destination tags, drives
// operand forwarding selects, inserts load-use bubbles and branch flushes.
module dc_fwd_ctrl #(
    parameter int AW        = 5,
    parameter int FWD_DEPTH = 3,
    parameter int LD_LAT    = 1,
    parameter int CNTW      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_wen,
    input  logic            id_is_load,
    input  logic            br_taken,
    output logic [1:0]      mux_sel_A,
    output logic [1:0]      mux_sel_B,
    output logic            stall_out,
    output logic            flush_out,
    output logic [AW-1:0]   rw_last,
    output logic            wen_last,
    output logic [CNTW-1:0] stall_cnt
);

    typedef enum logic {RUN, FLUSH} state_t;

    // Index k holds stage k+1 (index 0 = EX).
    state_t                       r_state;
    logic [FWD_DEPTH-1:0]         r_vld;
    logic [FWD_DEPTH-1:0]         r_ld;
    logic [FWD_DEPTH-1:0][AW-1:0] r_dst;
    logic [CNTW-1:0]              r_cnt;

    logic       w_hz;
    logic       w_stall;
    logic       w_issue;
    logic       w_tag_vld;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // Walk oldest to youngest so the youngest qualifying stage overrides.
    always_comb begin
        w_hz    = 1'b0;
        w_sel_a = 2'd0;
        w_sel_b = 2'd0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (r_vld[k] && !(r_ld[k] && (k < LD_LAT))) begin
                if ((r_dst[k] == id_rs) && (id_rs != '0)) w_sel_a = 2'(k + 1);
                if ((r_dst[k] == id_rt) && (id_rt != '0)) w_sel_b = 2'(k + 1);
            end
            if ((k < LD_LAT) && r_vld[k] && r_ld[k] && (r_dst[k] != '0) &&
                ((r_dst[k] == id_rs) || (r_dst[k] == id_rt)))
                w_hz = 1'b1;
        end
        w_hz = w_hz & id_valid;
    end

    assign w_stall   = (r_state == RUN) && w_hz && !br_taken;
    assign w_issue   = id_valid && !w_stall && (r_state == RUN) && !br_taken;
    assign w_tag_vld = w_issue && id_wen && (id_rd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_vld   <= '0;
            r_ld    <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
        end else begin
            r_vld[0] <= w_tag_vld;
            r_ld[0]  <= w_tag_vld && id_is_load;
            r_dst[0] <= w_tag_vld ? id_rd : '0;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_dst[k] <= r_dst[k-1];
            end
            r_state <= br_taken ? FLUSH : RUN;
            if (w_stall && (r_cnt != '1))
                r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign mux_sel_A = w_sel_a;
    assign mux_sel_B = w_sel_b;
    assign stall_out = w_stall;
    assign flush_out = (r_state == FLUSH);
    assign rw_last   = r_dst[FWD_DEPTH-1];
    assign wen_last  = r_vld[FWD_DEPTH-1];
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_dc_fwd_ctrl.sv
// Scoreboard bench for dc_fwd_ctrl: default build (u0) and an LD_LAT=2 /
// CNTW=4 build (u1) share stimulus; each vector names the build it checks.
module tb_dc_fwd_ctrl;

    localparam int X = -1;

    typedef struct {
        int tag;
        int dut;
        int a, b, s, f, c, w, r;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_wen = 1'b0, id_is_load = 1'b0, br_taken = 1'b0;

    logic [1:0]  sa0, sb0, sa1, sb1;
    logic        st0, fl0, wl0, st1, fl1, wl1;
    logic [4:0]  rw0, rw1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_tag = 0;

    always #5 clk = ~clk;

    dc_fwd_ctrl u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .br_taken(br_taken),
        .mux_sel_A(sa0), .mux_sel_B(sb0), .stall_out(st0), .flush_out(fl0),
        .rw_last(rw0), .wen_last(wl0), .stall_cnt(cnt0)
    );

    dc_fwd_ctrl #(.AW(5), .FWD_DEPTH(3), .LD_LAT(2), .CNTW(4)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .br_taken(br_taken),
        .mux_sel_A(sa1), .mux_sel_B(sb1), .stall_out(st1), .flush_out(fl1),
        .rw_last(rw1), .wen_last(wl1), .stall_cnt(cnt1)
    );

    function automatic exp_t ex(input int dut, input int a, input int b, input int s,
                                input int f, input int c, input int w, input int r);
        exp_t e;
        e.tag = 0; e.dut = dut;
        e.a = a; e.b = b; e.s = s; e.f = f; e.c = c; e.w = w; e.r = r;
        return e;
    endfunction

    task automatic chk(input int tag, input int dut, input string nm, input int act, input int req);
        if (req < 0) return;
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL vec%0d u%0d %s: got %0d, expected %0d", tag, dut, nm, act, req);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; mid = async reset pulse
    // raised inside the cycle, ahead of the sampling edge.
    task automatic step(input logic rst_v, input logic mid, input logic v,
                        input int rs, input int rt, input int rd,
                        input logic wen, input logic ld, input logic br, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst_v; id_valid = v;
        id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
        id_wen = wen; id_is_load = ld; br_taken = br;
        if (mid) begin
            #2;
            reset = 1'b1;
        end
        e.tag = n_tag++;
        sb_q.push_back(e);
    endtask

    task automatic idle(input exp_t e);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.dut == 0) begin
                chk(e.tag, 0, "mux_sel_A", int'(sa0), e.a);
                chk(e.tag, 0, "mux_sel_B", int'(sb0), e.b);
                chk(e.tag, 0, "stall_out", int'(st0), e.s);
                chk(e.tag, 0, "flush_out", int'(fl0), e.f);
                chk(e.tag, 0, "stall_cnt", int'(cnt0), e.c);
                chk(e.tag, 0, "wen_last",  int'(wl0), e.w);
                chk(e.tag, 0, "rw_last",   int'(rw0), e.r);
            end else begin
                chk(e.tag, 1, "mux_sel_A", int'(sa1), e.a);
                chk(e.tag, 1, "mux_sel_B", int'(sb1), e.b);
                chk(e.tag, 1, "stall_out", int'(st1), e.s);
                chk(e.tag, 1, "flush_out", int'(fl1), e.f);
                chk(e.tag, 1, "stall_cnt", int'(cnt1), e.c);
                chk(e.tag, 1, "wen_last",  int'(wl1), e.w);
                chk(e.tag, 1, "rw_last",   int'(rw1), e.r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        // u0: reset state, then forwarding distance 1..3 and drop-out
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 1, 1, 2, 3, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 1, 3, 4, 6, 1, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, X));
        step(0, 0, 1, 3, 0, 0, 0, 0, 0, ex(0, 2, 0, 0, 0, 0, 0, X));
        step(0, 0, 1, 3, 0, 0, 0, 0, 0, ex(0, 3, 0, 0, 0, 0, 1, 3));
        step(0, 0, 1, 3, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 1, 6));
        idle(ex(0, 0, 0, 0, 0, 0, 0, X));
        // u0: load-use, LD_LAT=1
        step(0, 0, 1, 1, 0, 5, 1, 1, 0, ex(0, 0, 0, 0, 0, 0, 0, X));
        step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(0, 0, 0, 1, 0, 0, X, X));
        step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(0, 0, 2, 0, 0, 1, X, X));
        idle(ex(0, 0, 0, 0, 0, 1, X, X));
        // u0: youngest r7 wins; r0 never tracked or forwarded
        step(0, 0, 1, 0, 0, 7, 1, 0, 0, ex(0, 0, 0, 0, 0, 1, X, X));
        step(0, 0, 1, 0, 0, 7, 1, 0, 0, ex(0, 0, 0, 0, 0, 1, X, X));
        step(0, 0, 1, 7, 7, 0, 1, 0, 0, ex(0, 1, 1, 0, 0, 1, X, X));
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, X, X));
        step(0, 0, 1, 7, 0, 0, 0, 0, 0, ex(0, 3, 0, 0, 0, 1, 1, 7));
        // u0: branch wins over load-use stall, then one flush cycle
        step(0, 0, 1, 1, 0, 5, 1, 1, 0, ex(0, 0, 0, 0, 0, 1, X, X));
        step(0, 0, 1, 0, 5, 9, 1, 0, 1, ex(0, 0, 0, 0, 0, 1, X, X));
        step(0, 0, 1, 0, 5, 9, 1, 0, 0, ex(0, 0, 2, 0, 1, 1, X, X));
        step(0, 0, 1, 9, 5, 10, 1, 0, 0, ex(0, 0, 3, 0, 0, 1, 1, 5));
        // u1: LD_LAT=2 gives a two-cycle stall
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 1, 1, 0, 5, 1, 1, 0, ex(1, 0, 0, 0, 0, 0, 0, X));
        step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(1, 0, 0, 1, 0, 0, X, X));
        step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(1, 0, 0, 1, 0, 1, X, X));
        step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(1, 0, 3, 0, 0, 2, X, X));
        idle(ex(1, 0, 0, 0, 0, 2, X, X));
        // u1: 20 more stall cycles (22 total) saturate the 4-bit counter
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 1, 0, 5, 1, 1, 0, ex(1, X, X, 0, X, X, X, X));
            step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(1, X, X, 1, X, X, X, X));
            step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(1, X, X, 1, X, X, X, X));
            step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(1, X, X, 0, X, X, X, X));
        end
        idle(ex(1, 0, 0, 0, 0, 15, X, X));
        // u1: async reset in the second stall cycle, then first issue
        step(0, 0, 1, 1, 0, 5, 1, 1, 0, ex(1, X, X, 0, 0, 15, X, X));
        step(0, 0, 1, 2, 5, 8, 1, 0, 0, ex(1, 0, 0, 1, 0, 15, X, X));
        step(0, 1, 1, 2, 5, 8, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 1, 0, 0, 9, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 1, 9, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, X));
        idle(ex(1, X, X, X, X, X, X, X));

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
